// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// operation encodings, FSM states and datapath sizing.
package ex_muldiv_pkg;

  localparam int DATA_W = 16;
  localparam int ITER   = 16;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/ex_muldiv_abs16.sv
// Conditional 16-bit negate: y = neg ? (~a + carry) : a. With carry=1 this is a
// plain two's-complement negate; carry lets two instances form a 32-bit negate.
module muldiv_abs16
  import ex_muldiv_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic              neg,
  input  logic              carry,
  output logic [DATA_W-1:0] y
);

  assign y = neg ? (~a + DATA_W'(carry)) : a;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative 16x16 multiply / 16/16 divide for the EX stage. Magnitudes are
// processed one bit per cycle and the result sign is restored in FIX.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic              abort_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              divz_o
);

  state_e            state;
  logic              is_div;
  logic              sign_q;
  logic              sign_r;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   rem;
  logic [DATA_W-1:0] quo;

  logic [DATA_W-1:0] rs_mag, rt_mag, fix_lo, fix_hi;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic              div_ge;

  muldiv_abs16 u_abs_a (.a(rs_i), .neg(op_i[0] & rs_i[DATA_W-1]), .carry(1'b1), .y(rs_mag));
  muldiv_abs16 u_abs_b (.a(rt_i), .neg(op_i[0] & rt_i[DATA_W-1]), .carry(1'b1), .y(rt_mag));

  // Product negate borrows across the halves; quotient and remainder negate independently.
  muldiv_abs16 u_fix_lo (.a(quo), .neg(sign_q), .carry(1'b1), .y(fix_lo));
  muldiv_abs16 u_fix_hi (.a(rem[DATA_W-1:0]), .neg(is_div ? sign_r : sign_q),
                         .carry(is_div | (quo == '0)), .y(fix_hi));

  assign mul_sum   = rem + {1'b0, (quo[0] ? a_mag : '0)};
  assign div_shift = {rem[DATA_W-1:0], quo[DATA_W-1]};
  assign div_ge    = (div_shift >= {1'b0, b_mag});
  assign div_diff  = div_shift - {1'b0, b_mag};

  assign stall_o = ~rst_i & (((state == S_IDLE) & start_i) | (state == S_CALC) | (state == S_FIX));
  assign busy_o  = ~rst_i & (state != S_IDLE);
  assign done_o  = ~rst_i & (state == S_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      cnt    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      rem    <= '0;
      quo    <= '0;
      hi_o   <= '0;
      lo_o   <= '0;
      divz_o <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            is_div <= op_i[1];
            cnt    <= '0;
            a_mag  <= rs_mag;
            // Divide by zero preloads the fixed result and bypasses the iterations.
            if (op_i[1] && (rt_i == '0)) begin
              divz_o <= 1'b1;
              sign_q <= 1'b0;
              sign_r <= 1'b0;
              b_mag  <= '0;
              rem    <= {1'b0, rs_i};
              quo    <= '1;
              state  <= S_FIX;
            end else begin
              divz_o <= 1'b0;
              sign_q <= op_i[0] & (rs_i[DATA_W-1] ^ rt_i[DATA_W-1]);
              sign_r <= op_i[0] & rs_i[DATA_W-1];
              b_mag  <= rt_mag;
              rem    <= '0;
              quo    <= op_i[1] ? rs_mag : rt_mag;
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (abort_i) begin
            state <= S_IDLE;
          end else begin
            if (is_div) begin
              rem <= div_ge ? div_diff : div_shift;
              quo <= {quo[DATA_W-2:0], div_ge};
            end else begin
              rem <= {1'b0, mul_sum[DATA_W:1]};
              quo <= {mul_sum[0], quo[DATA_W-1:1]};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'(ITER - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (abort_i) begin
            state <= S_IDLE;
          end else begin
            hi_o  <= fix_hi;
            lo_o  <= fix_lo;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [15:0] rs_i = '0;
  logic [15:0] rt_i = '0;
  logic        abort_i = 1'b0;
  logic        stall_o, busy_o, done_o, divz_o;
  logic [15:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  ex_muldiv dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .abort_i(abort_i), .stall_o(stall_o),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o), .divz_o(divz_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Returns {divz, hi, lo} from plain integer arithmetic.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, p, q, r;
    logic [31:0] p32;
    logic [15:0] q16, r16;
    sa = op[0] ? longint'($signed(a)) : longint'(a);
    sb = op[0] ? longint'($signed(b)) : longint'(b);
    if (!op[1]) begin
      p   = sa * sb;
      p32 = 32'(p);
      return {1'b0, p32};
    end
    if (b == 16'h0) return {1'b1, a, 16'hFFFF};
    q   = sa / sb;
    r   = sa % sb;
    q16 = 16'(q);
    r16 = 16'(r);
    return {1'b0, r16, q16};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom % 8)
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Starts one operation from IDLE (called at a negedge) and checks the whole transaction.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [32:0] exp;
    logic [15:0] hi0, lo0;
    logic        stall_ok, hold_ok;
    int          cyc;
    exp = model(op, a, b);
    hi0 = hi_o;
    lo0 = lo_o;
    start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
    abort_i = 1'($urandom % 2);
    #1;
    check("stall_cycle0", stall_o, 1);
    @(negedge clk_i);
    cyc = 1;
    abort_i = 1'b0;
    check("divz_after_start", divz_o, exp[32]);
    stall_ok = 1'b1;
    hold_ok  = 1'b1;
    while (!done_o && cyc < 40) begin
      if (!stall_o || !busy_o) stall_ok = 1'b0;
      if (hi_o !== hi0 || lo_o !== lo0) hold_ok = 1'b0;
      // Inputs wander while busy; the latched operands must be used.
      start_i = 1'($urandom % 2);
      op_i    = 2'($urandom);
      rs_i    = 16'($urandom);
      rt_i    = 16'($urandom);
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    check("latency", cyc, exp[32] ? 2 : 18);
    check("stall_while_busy", stall_ok, 1);
    check("hilo_hold", hold_ok, 1);
    check("stall_in_done", stall_o, 0);
    check("hi", hi_o, exp[31:16]);
    check("lo", lo_o, exp[15:0]);
    check("divz", divz_o, exp[32]);
    abort_i = 1'($urandom % 2);
    @(negedge clk_i);
    abort_i = 1'b0;
    check("done_one_cycle", done_o, 0);
    check("idle_after_done", busy_o, 0);
    check("lo_after_done", lo_o, exp[15:0]);
  endtask

  initial begin
    logic saw_done;

    // Reset with start held high: stall must stay low.
    start_i = 1'b1;
    @(negedge clk_i);
    check("rst_stall", stall_o, 0);
    @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_divz", divz_o, 0);
    rst_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);

    run_op(2'b00, 16'hFFFF, 16'hFFFF);
    check("mulu_ffff_hi", hi_o, 32'hFFFE);
    check("mulu_ffff_lo", lo_o, 32'h0001);
    run_op(2'b01, 16'hFFFD, 16'h0007);
    run_op(2'b11, 16'hFFF9, 16'h0002);
    run_op(2'b10, 16'd100, 16'd7);
    check("divu_100_7_lo", lo_o, 32'd14);
    run_op(2'b10, 16'h1234, 16'h0000);
    repeat (3) @(negedge clk_i);
    check("divz_sticky", divz_o, 1);
    run_op(2'b11, 16'h8000, 16'hFFFF);
    check("div_ovf_lo", lo_o, 32'h8000);

    // Abort mid-CALC: outputs keep the previous result.
    run_op(2'b00, 16'hFFFF, 16'hFFFF);
    start_i = 1'b1; op_i = 2'b00; rs_i = 16'd3; rt_i = 16'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_stall", stall_o, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_o) saw_done = 1'b1;
      @(negedge clk_i);
    end
    check("abort_no_done", saw_done, 0);
    check("abort_hi", hi_o, 32'hFFFE);
    check("abort_lo", lo_o, 32'h0001);

    // Reset mid-operation.
    start_i = 1'b1; op_i = 2'b00; rs_i = 16'd3; rt_i = 16'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    start_i = 1'b1;
    #1;
    check("midrst_stall", stall_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    start_i = 1'b0;
    check("midrst_hi", hi_o, 0);
    check("midrst_lo", lo_o, 0);
    check("midrst_divz", divz_o, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_o || busy_o) saw_done = 1'b1;
      @(negedge clk_i);
    end
    check("midrst_discard", saw_done, 0);
    run_op(2'b00, 16'd3, 16'd5);
    check("after_rst_lo", lo_o, 32'd15);

    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom), pick(), pick());
      repeat ($urandom % 3) @(negedge clk_i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
